// File: rtl/layer_sequencer.sv
// layer_sequencer: walks every neuron and every input of a dense layer on one
// shared MAC, adds the bias, rescales by FRAC_BITS, saturates to 16 bits and
// writes each neuron result to the output buffer.
// Optional build macro: LAYER_SEQUENCER_RELU_EN (clamp negative results to 0).
module layer_sequencer #(
  parameter int INPUT_SIZE   = 784,
  parameter int NUM_NEURONS  = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int W_ADDR_WIDTH = 14,
  parameter int N_WIDTH      = 4,
  parameter int FRAC_BITS    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic signed [15:0]      in_data,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  input  logic signed [15:0]      w_data,
  output logic [N_WIDTH-1:0]      b_addr,
  input  logic signed [15:0]      b_data,
  output logic                    out_we,
  output logic [N_WIDTH-1:0]      out_addr,
  output logic signed [15:0]      out_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_BIAS, S_WRITE, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(INPUT_SIZE - 1);
  localparam logic [N_WIDTH-1:0]    LAST_N = N_WIDTH'(NUM_NEURONS - 1);
  localparam logic signed [47:0]    SAT_MAX = 48'sd32767;
  localparam logic signed [47:0]    SAT_MIN = -48'sd32768;

  state_t                   state, state_nx;
  logic [ADDR_WIDTH-1:0]    i;
  logic [N_WIDTH-1:0]       n;
  logic [W_ADDR_WIDTH-1:0]  w_cnt;
  logic                     valid_d;
  logic signed [47:0]       acc;
  logic signed [31:0]       prod;
  logic signed [47:0]       bias_ext;
  logic signed [47:0]       sum;
  logic signed [47:0]       r;
  logic signed [15:0]       res;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (i == LAST_I) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_BIAS;
      S_BIAS:  state_nx = S_WRITE;
      S_WRITE: state_nx = (n == LAST_N) ? S_DONE : S_RUN;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bias add, rescale (floor shift), saturate and optional ReLU
  always_comb begin
    prod     = in_data * w_data;
    bias_ext = 48'(b_data);
    sum      = acc + (bias_ext <<< FRAC_BITS);
    r        = sum >>> FRAC_BITS;
    if (r > SAT_MAX)      res = 16'sh7fff;
    else if (r < SAT_MIN) res = -16'sh8000;
    else                  res = r[15:0];
`ifdef LAYER_SEQUENCER_RELU_EN
    if (res[15]) res = '0;
`endif
  end

  // Counters, delayed-valid MAC and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i        <= '0;
      n        <= '0;
      w_cnt    <= '0;
      valid_d  <= 1'b0;
      acc      <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      valid_d <= (state == S_RUN);
      if (valid_d) acc <= acc + 48'(prod);
      case (state)
        S_IDLE: begin
          if (start) begin
            i     <= '0;
            n     <= '0;
            w_cnt <= '0;
            acc   <= '0;
          end
        end
        S_RUN: begin
          // w_cnt runs across neurons so the weight address needs no multiply
          w_cnt <= w_cnt + 1'b1;
          if (i != LAST_I) i <= i + 1'b1;
        end
        S_BIAS: begin
          out_data <= res;
          out_addr <= n;
        end
        S_WRITE: begin
          acc <= '0;
          if (n != LAST_N) begin
            n <= n + 1'b1;
            i <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign out_we  = (state == S_WRITE);
  assign in_addr = i;
  assign w_addr  = w_cnt;
  assign b_addr  = n;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: INPUT_SIZE=4, NUM_NEURONS=2, one
// instance at FRAC_BITS=0 and one at FRAC_BITS=15 sharing the same stimulus.
module tb_layer_sequencer;

`ifdef LAYER_SEQUENCER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] in_data = '0, w_data = '0, b_data = '0;

  logic busy0, done0, we0;
  logic [1:0] ia0;
  logic [2:0] wa0;
  logic ba0, oa0;
  logic signed [15:0] od0;

  logic busy1, done1, we1;
  logic [1:0] ia1;
  logic [2:0] wa1;
  logic ba1, oa1;
  logic signed [15:0] od1;

  logic signed [15:0] in_mem [4];
  logic signed [15:0] w_mem  [8];
  logic signed [15:0] b_mem  [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.INPUT_SIZE(4), .NUM_NEURONS(2), .ADDR_WIDTH(2),
                    .W_ADDR_WIDTH(3), .N_WIDTH(1), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .in_addr(ia0), .in_data(in_data), .w_addr(wa0), .w_data(w_data),
    .b_addr(ba0), .b_data(b_data), .out_we(we0), .out_addr(oa0),
    .out_data(od0));

  layer_sequencer #(.INPUT_SIZE(4), .NUM_NEURONS(2), .ADDR_WIDTH(2),
                    .W_ADDR_WIDTH(3), .N_WIDTH(1), .FRAC_BITS(15)) dut15 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .in_addr(ia1), .in_data(in_data), .w_addr(wa1), .w_data(w_data),
    .b_addr(ba1), .b_data(b_data), .out_we(we1), .out_addr(oa1),
    .out_data(od1));

  // Synchronous-read memories: data follows the address by one cycle
  always @(posedge clk) begin
    in_data <= in_mem[ia0];
    w_data  <= w_mem[wa0];
    b_data  <= b_mem[ba0];
  end

  task automatic load(input logic signed [15:0] iv, input logic signed [15:0] wv,
                      input logic signed [15:0] bv);
    for (int k = 0; k < 4; k++) in_mem[k] = iv;
    for (int k = 0; k < 8; k++) w_mem[k] = wv;
    for (int k = 0; k < 2; k++) b_mem[k] = bv;
  endtask

  // Returns just after edge 0 (the edge sampling start)
  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy0, done0, we0, ia0, wa0, ba0, oa0, od0} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%0b done=%0b we=%0b ia=%0d wa=%0d ba=%0d oa=%0d od=%0d want all 0",
               busy0, done0, we0, ia0, wa0, ba0, oa0, od0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load(16'sd1, 16'sd2, 16'sd3);
    kick();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      total++;
      if (busy0 !== (c <= 15)) begin
        bad++; $display("FAIL basic_busy cycle %0d got %0b want %0b", c, busy0, (c <= 15));
      end
      total++;
      if (done0 !== (c == 15)) begin
        bad++; $display("FAIL basic_done cycle %0d got %0b want %0b", c, done0, (c == 15));
      end
      total++;
      if (we0 !== (c == 7 || c == 14)) begin
        bad++; $display("FAIL basic_we cycle %0d got %0b want %0b", c, we0, (c == 7 || c == 14));
      end
      if (c == 7 || c == 14) begin
        total++;
        if (oa0 !== (c == 14)) begin
          bad++; $display("FAIL basic_out_addr cycle %0d got %0d want %0d", c, oa0, (c == 14));
        end
        total++;
        if (od0 !== 16'sd11) begin
          bad++; $display("FAIL basic_out_data cycle %0d got %0d want 11", c, od0);
        end
      end
    end
  endtask

  task automatic test_addr_seq();
    logic [1:0] ei;
    logic [2:0] ew;
    logic       eb;
    load(16'sd1, 16'sd2, 16'sd3);
    kick();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if ((c >= 1 && c <= 4) || (c >= 8 && c <= 11)) begin
        eb = (c >= 8);
        ei = eb ? 2'(c - 8) : 2'(c - 1);
        ew = eb ? 3'(c - 4) : 3'(c - 1);
        total++;
        if (ia0 !== ei || wa0 !== ew || ba0 !== eb) begin
          bad++;
          $display("FAIL addr_seq cycle %0d got in=%0d w=%0d b=%0d want in=%0d w=%0d b=%0d",
                   c, ia0, wa0, ba0, ei, ew, eb);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] exp_neg;
    exp_neg = RELU ? 16'sd0 : -16'sd32768;
    load(16'sd32767, 16'sd32767, 16'sd0);
    kick();
    repeat (7) @(negedge clk);
    total++;
    if (we1 !== 1'b1 || od1 !== 16'sd32767) begin
      bad++; $display("FAIL sat_pos got we=%0b od=%0d want we=1 od=32767", we1, od1);
    end
    repeat (9) @(negedge clk);
    load(16'sd32767, -16'sd32768, 16'sd0);
    kick();
    repeat (14) @(negedge clk);
    total++;
    if (we1 !== 1'b1 || oa1 !== 1'b1 || od1 !== exp_neg) begin
      bad++; $display("FAIL sat_neg got we=%0b oa=%0d od=%0d want we=1 oa=1 od=%0d", we1, oa1, od1, exp_neg);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_neg_bias();
    logic signed [15:0] exp_v;
    exp_v = RELU ? 16'sd0 : -16'sd5;
    load(16'sd0, 16'sd7, -16'sd5);
    kick();
    repeat (7) @(negedge clk);
    total++;
    if (we0 !== 1'b1 || od0 !== exp_v) begin
      bad++; $display("FAIL neg_bias got we=%0b od=%0d want we=1 od=%0d", we0, od0, exp_v);
    end
    repeat (9) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    load(16'sd1, 16'sd2, 16'sd3);
    kick();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy0 !== 1'b0 || we0 !== 1'b0 || done0 !== 1'b0 || od0 !== 16'sd0) begin
      bad++; $display("FAIL reset_mid got busy=%0b we=%0b done=%0b od=%0d want 0 0 0 0", busy0, we0, done0, od0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (we0 !== 1'b0 || busy0 !== 1'b0) begin
        bad++; $display("FAIL reset_no_write idle cycle %0d got we=%0b busy=%0b want 0 0", c, we0, busy0);
      end
    end
    test_basic();
  endtask

  task automatic test_back_to_back();
    int dones, writes;
    load(16'sd1, 16'sd2, 16'sd3);
    dones = 0; writes = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (done0) dones++;
      if (we0) begin
        writes++;
        total++;
        if (od0 !== 16'sd11) begin
          bad++; $display("FAIL b2b_data cycle %0d got %0d want 11", c, od0);
        end
      end
      if (c == 16) begin
        total++;
        if (busy0 !== 1'b0 || dones != 1 || writes != 2) begin
          bad++; $display("FAIL b2b_first got busy=%0b dones=%0d writes=%0d want 0 1 2", busy0, dones, writes);
        end
        dones = 0; writes = 0;
      end
      if (c == 17) begin
        total++;
        if (busy0 !== 1'b1) begin
          bad++; $display("FAIL b2b_restart got busy=%0b want 1", busy0);
        end
        start = 1'b0;
      end
      if (c == 25) start = 1'b1;
      if (c == 26) start = 1'b0;
      if (c == 31) begin
        total++;
        if (done0 !== 1'b1) begin
          bad++; $display("FAIL b2b_done2 got %0b want 1", done0);
        end
      end
    end
    total++;
    if (busy0 !== 1'b0 || dones != 1 || writes != 2) begin
      bad++; $display("FAIL b2b_second got busy=%0b dones=%0d writes=%0d want 0 1 2", busy0, dones, writes);
    end
  endtask

  initial begin
    load(16'sd0, 16'sd0, 16'sd0);
    test_reset();
    test_basic();
    test_addr_seq();
    test_saturation();
    test_neg_bias();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Time-multiplexed controller that computes a full dense layer on one shared multiply-accumulate datapath. It walks every neuron of the layer and every input of each neuron, drives read addresses into the input buffer, the weight ROM and the bias ROM, and accumulates products. For each neuron it adds the bias, rescales, saturates to 16 bits and writes the result to the layer output buffer. It sits between the input-vector buffer and the next layer's input buffer and is started by the network-level controller.

## Interface
Parameters:
- INPUT_SIZE, 784, inputs per neuron (≥2)
- NUM_NEURONS, 16, neurons in the layer (≥1)
- ADDR_WIDTH, 10, input-buffer address width (2^ADDR_WIDTH ≥ INPUT_SIZE)
- W_ADDR_WIDTH, 14, weight-ROM address width (2^W_ADDR_WIDTH ≥ INPUT_SIZE*NUM_NEURONS)
- N_WIDTH, 4, neuron index width (2^N_WIDTH ≥ NUM_NEURONS)
- FRAC_BITS, 15, fractional bits of weights; the product is arithmetic-shifted right by this amount

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse, layer complete
- in_addr  out  ADDR_WIDTH  input-buffer read address
- in_data  in  16 signed  input value, valid one cycle after in_addr
- w_addr  out  W_ADDR_WIDTH  weight-ROM address
- w_data  in  16 signed  weight, valid one cycle after w_addr
- b_addr  out  N_WIDTH  bias-ROM address (current neuron)
- b_data  in  16 signed  bias in output Q format, valid one cycle after b_addr
- out_we  out  1  output-buffer write strobe
- out_addr  out  N_WIDTH  output-buffer write address
- out_data  out  16 signed  neuron result

## Operation
- FSM states: IDLE, RUN, DRAIN, BIAS, WRITE, DONE.
- IDLE: busy=0. On start=1, clear n, i, w_addr and acc, then go to RUN.
- RUN: drive in_addr=i, w_addr=n*INPUT_SIZE+i (running counter, no multiplier) and b_addr=n. A one-cycle-delayed valid qualifies accumulation: acc += in_data*w_data.
  - At i==INPUT_SIZE-1, go to DRAIN.
- DRAIN: accumulate the final product; no new address is issued.
- BIAS: compute sum = acc + (b_data sign-extended <<< FRAC_BITS), then r = sum >>> FRAC_BITS (floor).
  - Saturate r to [-32768, 32767].
  - Register the result into out_data, with out_addr=n.
- WRITE: out_we=1 for exactly this cycle, and acc is cleared.
  - If n==NUM_NEURONS-1, go to DONE.
  - Otherwise n++, i=0, and go to RUN. w_addr continues contiguously.
- DONE: done=1 for one cycle, then IDLE.
- Accumulator is 48-bit signed; products are 32-bit signed. Overflow is impossible at INPUT_SIZE ≤ 65536.
- start while busy is ignored. No queuing.
- in_data and w_data are ignored outside the delayed-valid window.

## Timing
- Reset values: all outputs are 0 (busy, done, out_we, in_addr, w_addr, b_addr, out_addr, out_data), and the FSM is in IDLE. acc, n and i are cleared.
- rst mid-operation aborts immediately and asynchronously. No partial write is issued after reset deasserts.
- Cycle 0 is the edge that samples start. RUN occupies cycles 1..INPUT_SIZE of neuron 0.
- Per neuron: INPUT_SIZE+3 cycles (RUN×INPUT_SIZE, DRAIN, BIAS, WRITE).
- The out_we of neuron k is in cycle (k+1)*(INPUT_SIZE+3).
- done is in cycle NUM_NEURONS*(INPUT_SIZE+3)+1.
- The earliest next start is accepted in the cycle after done, i.e. back in IDLE.
- out_data holds its last written value until the next BIAS state or reset.

## Configuration
- LAYER_SEQUENCER_RELU_EN defined: after saturation, negative results are written as 0 (ReLU for hidden layers).
- Not defined: the saturated signed result is written unchanged (output layer).

## Test plan
All scenarios use INPUT_SIZE=4, NUM_NEURONS=2, FRAC_BITS=0 unless stated.
- Basic: inputs=1, weights=2, biases=3.
  - out_we in cycles 7 and 14 with out_addr 0/1, out_data 11 each.
  - done only in cycle 15; busy high cycles 1–15.
- Address sequence: w_addr 0,1,2,3 then 4,5,6,7; in_addr 0..3 twice; b_addr 0 then 1.
- Saturation, FRAC_BITS=15:
  - Inputs 32767 and weights 32767 give 32767.
  - Weights -32768 give -32768 without the macro and 0 with LAYER_SEQUENCER_RELU_EN.
- Negative bias: inputs 0, bias -5 gives out_data -5 without the macro and 0 with it.
- Reset mid-RUN: assert rst in cycle 3.
  - busy, out_we and done go to 0 immediately, and no writes occur.
  - A fresh start then reproduces the Basic results exactly.
- start held high or re-pulsed while busy: exactly one done pulse and two writes per accepted start; a start in the cycle after done begins a new run.
